axis_xbar_switch: RTL
=====================

# axis_xbar_switch

Parametrised packet-switching crossbar for the switch datapath. It connects PORT_NUM AXI-Stream receive ports to PORT_NUM transmit FIFO ports, with generic data width and per-output round-robin arbitration. Each output is locked to one input from the first beat of a packet through its tlast. Packets with an illegal destination are dropped and counted. It replaces the fixed 32-bit crossbar plus separate select interconnect with one self-contained block that sits between the frame decoders and the transmit FIFOs.

## Interface
Parameters:
- PORT_NUM, 4: number of input ports and number of output ports (2..16)
- DATA_W, 32: tdata width per port; a multiple of 8. KEEP_W = DATA_W/8
- CNT_W, 16: width of the drop counter

Ports (input port i and output port o occupy slice [i*W +: W] of each flat bus):
- glb_clk  in  1  the single clock. Everything is on the rising edge.
- glb_areset_n  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  PORT_NUM  input valid
- s_axis_tready  out  PORT_NUM  input ready
- s_axis_tdata  in  PORT_NUM*DATA_W  input data
- s_axis_tkeep  in  PORT_NUM*KEEP_W  input byte enables
- s_axis_tlast  in  PORT_NUM  input end of packet
- s_axis_tdest  in  PORT_NUM*PORT_NUM  one-hot destination mask per input; only sampled on the first beat
- m_axis_tvalid  out  PORT_NUM  output valid
- m_axis_tready  in  PORT_NUM  output ready
- m_axis_tdata  out  PORT_NUM*DATA_W  output data
- m_axis_tkeep  out  PORT_NUM*KEEP_W  output byte enables
- m_axis_tlast  out  PORT_NUM  output end of packet
- out_grant_en  in  PORT_NUM  per output: 1 allows a new grant (driven from FIFO space); it does not affect a packet already in flight
- out_busy  out  PORT_NUM  output is locked to an input
- drop_cnt  out  CNT_W  number of dropped packets; saturates at all-ones
- drop_cnt_clr  in  1  synchronous clear of drop_cnt

## Operation
Per-input state machine, states IDLE / FWD / DROP:
- IDLE: the input is at a packet boundary. A request to output o is s_axis_tvalid[i] & tdest[i][o].
- IDLE -> FWD: when output o grants input i.
- IDLE -> DROP: when tvalid=1 and tdest is zero or has more than one bit set. This is decided in the same cycle the beat is first seen.
- FWD: s_axis_tready[i] = m_axis_tready[o]. Returns to IDLE on an accepted beat with tlast=1.
- DROP: s_axis_tready[i]=1. Beats are discarded. On the accepted tlast beat, drop_cnt increments and the state returns to IDLE.
- In IDLE, s_axis_tready[i]=0. In DROP it is 1, including the first beat.

Per-output arbiter, states FREE / LOCKED:
- FREE: if out_grant_en[o]=1 and at least one request exists, grant the first requester at or after rr_ptr[o], searching in increasing index order with wrap-around. The grant is registered.
- LOCKED: the output mux selects the granted input. m_axis_* = s_axis_*[g] combinationally and out_busy[o]=1.
- LOCKED -> FREE: on an accepted tlast beat. At the same time rr_ptr[o] is set to (g+1) mod PORT_NUM.
- Each input requests only one output, so no input is granted by two outputs at once.
- Deasserting out_grant_en mid-packet does not stall the packet.
- A single-beat packet (tlast on the first beat) is legal: LOCKED for one accepted beat.
- tdest is ignored after the first beat.

drop_cnt:
- Holds at 2^CNT_W-1.
- drop_cnt_clr has priority over an increment in the same cycle; the result is 0.

## Timing
- Reset: all inputs IDLE, all outputs FREE, rr_ptr=0, drop_cnt=0. s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0 (outputs forced to zero while FREE), out_busy=0.
- Reset asserted mid-packet: grants are discarded immediately. After release, the remaining beats of that packet arrive in IDLE and are treated as a new packet using their tdest.
- Grant latency: first beat valid at cycle N gives the grant at edge N+1. The beat is presented on m_axis in cycle N+1; it transfers in N+1 if m_axis_tready=1.
- Throughput: one beat per cycle while locked. One idle cycle on the output after each packet (re-arbitration bubble).
- Drop: the first beat is accepted in cycle N itself; there is no added latency.
- No combinational path from m_axis_tready to m_axis_tvalid. There is a combinational path m_axis_tready -> s_axis_tready, by design.

## Test plan
- PORT_NUM=4, DATA_W=32. Input 0 sends 3 beats (0xA0..0xA2) with tdest=0b0100 -> output 2 shows the same 3 beats starting 1 cycle after the first valid, tlast on 0xA2, out_busy[2] high for 3 cycles.
- Inputs 0, 1 and 3 each send a 2-beat packet to output 1 simultaneously, repeated twice -> grant order 0,1,3,0,1,3, with a 1-cycle gap between packets.
- Input 2 sends tdest=0b0011 (3 beats), then tdest=0 (1 beat) -> both packets consumed with tready=1 and nothing appears on any output; drop_cnt=2. Pulsing drop_cnt_clr gives 0. CNT_W=2 with 5 drops gives 3.
- out_grant_en[3]=0 while input 1 requests output 3 -> no grant and s_axis_tready[1]=0. Raise it -> grant on the next edge. Lowering it mid-packet -> the packet completes.
- Random m_axis_tready backpressure (50%) on all outputs with all-to-all traffic -> scoreboard shows no loss or reordering within a source/destination pair, and tkeep is preserved.
- Assert reset after beat 2 of a 5-beat packet -> all outputs idle the next cycle; after release, the remaining beats are routed by their own tdest.

Source files
------------

// File: rtl/axis_xbar_switch.sv
// PORT_NUM x PORT_NUM AXI-Stream packet crossbar with per-output round-robin
// arbitration, packet locking and drop handling for illegal destinations.
module axis_xbar_switch #(
  parameter int PORT_NUM = 4,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic                         glb_clk,
  input  logic                         glb_areset_n,
  input  logic [PORT_NUM-1:0]          s_axis_tvalid,
  output logic [PORT_NUM-1:0]          s_axis_tready,
  input  logic [PORT_NUM*DATA_W-1:0]   s_axis_tdata,
  input  logic [PORT_NUM*DATA_W/8-1:0] s_axis_tkeep,
  input  logic [PORT_NUM-1:0]          s_axis_tlast,
  input  logic [PORT_NUM*PORT_NUM-1:0] s_axis_tdest,
  output logic [PORT_NUM-1:0]          m_axis_tvalid,
  input  logic [PORT_NUM-1:0]          m_axis_tready,
  output logic [PORT_NUM*DATA_W-1:0]   m_axis_tdata,
  output logic [PORT_NUM*DATA_W/8-1:0] m_axis_tkeep,
  output logic [PORT_NUM-1:0]          m_axis_tlast,
  input  logic [PORT_NUM-1:0]          out_grant_en,
  output logic [PORT_NUM-1:0]          out_busy,
  output logic [CNT_W-1:0]             drop_cnt,
  input  logic                         drop_cnt_clr
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]          in_state [PORT_NUM];
  logic [PORT_NUM-1:0] locked;
  logic [IDX_W-1:0]    gnt      [PORT_NUM];
  logic [IDX_W-1:0]    rr_ptr   [PORT_NUM];
  logic [CNT_W-1:0]    drop_cnt_q;

  logic [PORT_NUM-1:0] dest     [PORT_NUM];
  logic [PORT_NUM-1:0] req      [PORT_NUM];
  logic [PORT_NUM-1:0] gnt_now;
  logic [IDX_W-1:0]    gnt_sel  [PORT_NUM];
  logic [PORT_NUM-1:0] in_granted;
  logic [PORT_NUM-1:0] drop_act;
  logic [PORT_NUM-1:0] drop_done;
  logic [PORT_NUM-1:0] fwd_rdy;
  logic [PORT_NUM-1:0] out_last;

  function automatic logic is_onehot(input logic [PORT_NUM-1:0] v);
    return (v != '0) && ((v & (v - PORT_NUM'(1))) == '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PORT_NUM-1:0] inc);
    logic [CNT_W-1:0] r;
    r = a;
    for (int k = 0; k < PORT_NUM; k++)
      if (inc[k] && (r != '1)) r = r + CNT_W'(1);
    return r;
  endfunction

  // Only idle inputs with a legal one-hot destination raise a request.
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      dest[i]     = s_axis_tdest[i*PORT_NUM +: PORT_NUM];
      drop_act[i] = (in_state[i] == ST_DROP) ||
                    ((in_state[i] == ST_IDLE) && s_axis_tvalid[i] && !is_onehot(dest[i]));
      drop_done[i] = drop_act[i] && s_axis_tvalid[i] && s_axis_tlast[i];
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      req[o] = '0;
      for (int i = 0; i < PORT_NUM; i++)
        req[o][i] = (in_state[i] == ST_IDLE) && s_axis_tvalid[i] &&
                    dest[i][o] && is_onehot(dest[i]);
    end
  end

  always_comb begin : arb
    logic [IDX_W-1:0] idx;
    idx        = '0;
    in_granted = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      gnt_now[o] = 1'b0;
      gnt_sel[o] = '0;
      if (!locked[o] && out_grant_en[o]) begin
        for (int k = 0; k < PORT_NUM; k++) begin
          idx = IDX_W'((int'(rr_ptr[o]) + k) % PORT_NUM);
          if (!gnt_now[o] && req[o][idx]) begin
            gnt_now[o] = 1'b1;
            gnt_sel[o] = idx;
          end
        end
      end
      if (gnt_now[o]) in_granted[gnt_sel[o]] = 1'b1;
    end
  end

  // Output mux is forced to zero while the output is free.
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      m_axis_tvalid[o]                     = locked[o] && s_axis_tvalid[gnt[o]];
      m_axis_tlast[o]                      = locked[o] && s_axis_tlast[gnt[o]];
      m_axis_tdata[o*DATA_W +: DATA_W]     = locked[o] ? s_axis_tdata[gnt[o]*DATA_W +: DATA_W] : '0;
      m_axis_tkeep[o*KEEP_W +: KEEP_W]     = locked[o] ? s_axis_tkeep[gnt[o]*KEEP_W +: KEEP_W] : '0;
      out_last[o] = m_axis_tvalid[o] && m_axis_tready[o] && m_axis_tlast[o];
    end
    out_busy = locked;
  end

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      fwd_rdy[i] = 1'b0;
      for (int o = 0; o < PORT_NUM; o++)
        if (locked[o] && (gnt[o] == IDX_W'(i)) && m_axis_tready[o]) fwd_rdy[i] = 1'b1;
    end
    s_axis_tready = fwd_rdy | drop_act;
  end

  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      for (int i = 0; i < PORT_NUM; i++) in_state[i] <= ST_IDLE;
      for (int o = 0; o < PORT_NUM; o++) begin
        gnt[o]    <= '0;
        rr_ptr[o] <= '0;
      end
      locked     <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < PORT_NUM; i++) begin
        case (in_state[i])
          ST_IDLE: begin
            if (in_granted[i])
              in_state[i] <= ST_FWD;
            else if (drop_act[i] && !s_axis_tlast[i])
              in_state[i] <= ST_DROP;
          end
          ST_FWD:  if (s_axis_tvalid[i] && fwd_rdy[i] && s_axis_tlast[i]) in_state[i] <= ST_IDLE;
          ST_DROP: if (drop_done[i]) in_state[i] <= ST_IDLE;
          default: in_state[i] <= ST_IDLE;
        endcase
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        if (locked[o]) begin
          if (out_last[o]) begin
            locked[o] <= 1'b0;
            rr_ptr[o] <= (gnt[o] == IDX_W'(PORT_NUM - 1)) ? '0 : gnt[o] + IDX_W'(1);
          end
        end else if (gnt_now[o]) begin
          locked[o] <= 1'b1;
          gnt[o]    <= gnt_sel[o];
        end
      end
      drop_cnt_q <= drop_cnt_clr ? '0 : sat_add(drop_cnt_q, drop_done);
    end
  end

  assign drop_cnt = drop_cnt_q;

endmodule
